// File: rtl/sw_ctrl_pkg.sv
// Shared encodings for the stopwatch run/stop/lap sequencer.
// State codes and the BCD terminal count live here.
package sw_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  function automatic logic is_run(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/sw_edge_det.sv
// Rising-edge detector for a debounced button level.
// PULSE is high for the one cycle where LVL is high and was low.
module sw_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic LVL,
  output logic PULSE
);

  logic prev;

  always_ff @(posedge CLK) begin
    if (RST) prev <= 1'b0;
    else     prev <= LVL;
  end

  assign PULSE = LVL & ~prev;

endmodule

// File: rtl/sw_run_ctrl.sv
// Stopwatch run/stop/lap sequencer: button commands, count
// tick prescaler, digit clear, lap snapshot and display mux.
import sw_ctrl_pkg::*;

module sw_run_ctrl #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTN_SS,
  input  logic        BTN_LR,
  input  logic [15:0] CNT_VAL,
  output logic        TICK,
  output logic        CLR,
  output logic [15:0] DISP_VAL,
  output logic        RUNNING,
  output logic        LAP_ACT,
  output logic        OVF
);

  localparam logic [31:0] PMAX = 32'(TICK_DIV - 1);

  state_t      state;
  state_t      nxt;
  logic        ss_p;
  logic        lr_raw;
  logic        lr_p;
  logic        lap_ld;
  logic        clr_nxt;
  logic        adv;
  logic        wrap;
  logic [31:0] pcnt;
  logic [15:0] lap_reg;

  sw_edge_det u_ss (
    .CLK   (CLK),
    .RST   (RST),
    .LVL   (BTN_SS),
    .PULSE (ss_p)
  );

  sw_edge_det u_lr (
    .CLK   (CLK),
    .RST   (RST),
    .LVL   (BTN_LR),
    .PULSE (lr_raw)
  );

  // Start/stop beats lap/reset when both land in one cycle.
  assign lr_p = lr_raw & ~ss_p;

  always_comb begin
    nxt     = state;
    lap_ld  = 1'b0;
    clr_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_p)      nxt     = RUN;
        else if (lr_p) clr_nxt = 1'b1;
      end
      RUN: begin
        if (ss_p) begin
          nxt = STOP;
        end else if (lr_p) begin
          nxt    = LAP;
          lap_ld = 1'b1;
        end
      end
      LAP: begin
        if (ss_p)      nxt = STOP;
        else if (lr_p) nxt = RUN;
      end
      STOP: begin
        if (ss_p) begin
          nxt = RUN;
        end else if (lr_p) begin
          nxt     = IDLE;
          clr_nxt = 1'b1;
        end
      end
    endcase
  end

  // Freeze on the stopping edge so no tick escapes into STOP.
  assign adv  = is_run(state) && is_run(nxt);
  assign wrap = adv && (pcnt == PMAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pcnt    <= 32'd0;
      lap_reg <= 16'd0;
      TICK    <= 1'b0;
      CLR     <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      state <= nxt;
      TICK  <= wrap;
      CLR   <= clr_nxt;
      if (clr_nxt)   pcnt <= 32'd0;
      else if (wrap) pcnt <= 32'd0;
      else if (adv)  pcnt <= pcnt + 32'd1;
      if (lap_ld) lap_reg <= CNT_VAL;
      if (clr_nxt)
        OVF <= 1'b0;
      else if (TICK && (CNT_VAL == BCD_MAX))
        OVF <= 1'b1;
    end
  end

  assign RUNNING  = is_run(state);
  assign LAP_ACT  = (state == LAP);
  assign DISP_VAL = LAP_ACT ? lap_reg : CNT_VAL;

endmodule

// File: tb/tb_sw_run_ctrl.sv
// Bench for sw_run_ctrl with a BCD digit-chain model on TICK/CLR.
// Expected tick times are queued at stimulus and popped on TICK.
module tb_sw_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bss;
  logic        blr;
  logic [15:0] cnt;
  logic        tick;
  logic        clr;
  logic [15:0] disp;
  logic        running;
  logic        lap_act;
  logic        ovf;

  logic        load_req;
  logic [15:0] load_val;
  logic        sb_on;
  int          cyc = 0;
  int          ntick = 0;
  int          total = 0;
  int          bad = 0;
  int          exp_q[$];

  sw_run_ctrl #(.TICK_DIV(4)) dut (
    .CLK      (clk),
    .RST      (rst),
    .BTN_SS   (bss),
    .BTN_LR   (blr),
    .CNT_VAL  (cnt),
    .TICK     (tick),
    .CLR      (clr),
    .DISP_VAL (disp),
    .RUNNING  (running),
    .LAP_ACT  (lap_act),
    .OVF      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || clr)     cnt <= 16'h0000;
    else if (load_req)  cnt <= load_val;
    else if (tick)      cnt <= bcd_inc(cnt);
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("tick_clr_excl", {31'd0, tick & clr}, 32'd0);
      if (tick) begin
        ntick++;
        chk("tick_in_run", {31'd0, running}, 32'd1);
        if (sb_on) begin
          if (exp_q.size() == 0)
            chk("tick_unexp", cyc, 32'hffff_ffff);
          else
            chk("tick_time", cyc, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int c;
    int n0;
    rst = 1'b1;
    bss = 1'b0;
    blr = 1'b0;
    load_req = 1'b0;
    load_val = 16'h0;
    sb_on = 1'b0;
    tk(3);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_clr", {31'd0, clr}, 32'd0);
    chk("rst_run", {31'd0, running}, 32'd0);
    chk("rst_lap", {31'd0, lap_act}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_disp", {16'd0, disp}, 32'd0);
    rst = 1'b0;
    tk(2);
    chk("idle_hold", {31'd0, running}, 32'd0);

    // run from reset, 10 ticks in 40 cycles
    c = cyc;
    bss = 1'b1;
    for (int k = 1; k <= 10; k++) exp_q.push_back(c + 1 + 4 * k);
    sb_on = 1'b1;
    tk(1);
    chk("s1_run", {31'd0, running}, 32'd1);
    tk(9);
    bss = 1'b0;
    tk(32);
    chk("s1_ticks", ntick, 32'd10);
    chk("s1_disp", {16'd0, disp}, 32'h0010);
    chk("s1_q", exp_q.size(), 32'd0);

    // stop at pcnt=2, resume keeps the fraction
    tk(1);
    bss = 1'b1;
    tk(1);
    chk("s2_stop", {31'd0, running}, 32'd0);
    bss = 1'b0;
    n0 = ntick;
    tk(50);
    chk("s2_no_tick", ntick - n0, 32'd0);
    c = cyc;
    bss = 1'b1;
    exp_q.push_back(c + 3);
    tk(1);
    chk("s2_resume", {31'd0, running}, 32'd1);
    bss = 1'b0;
    tk(3);
    chk("s2_q", exp_q.size(), 32'd0);
    chk("s2_disp", {16'd0, disp}, 32'h0011);
    sb_on = 1'b0;

    // lap snapshot while counting continues
    load_val = 16'h0123;
    load_req = 1'b1;
    tk(1);
    load_req = 1'b0;
    blr = 1'b1;
    tk(1);
    chk("s3_lap", {31'd0, lap_act}, 32'd1);
    chk("s3_disp", {16'd0, disp}, 32'h0123);
    n0 = ntick;
    tk(8);
    chk("s3_ticks", ntick - n0, 32'd2);
    chk("s3_hold", {16'd0, disp}, 32'h0123);
    chk("s3_live_cnt", {16'd0, cnt}, 32'h0125);
    chk("s3_run", {31'd0, running}, 32'd1);
    blr = 1'b0;
    tk(1);
    blr = 1'b1;
    tk(1);
    chk("s3_unlap", {31'd0, lap_act}, 32'd0);
    chk("s3_run2", {31'd0, running}, 32'd1);
    chk("s3_live", {16'd0, disp}, {16'd0, cnt});
    blr = 1'b0;

    // stop then reset, then reset again from idle
    bss = 1'b1;
    tk(1);
    chk("s4_stop", {31'd0, running}, 32'd0);
    bss = 1'b0;
    tk(2);
    blr = 1'b1;
    tk(1);
    chk("s4_clr", {31'd0, clr}, 32'd1);
    chk("s4_idle", {31'd0, running}, 32'd0);
    chk("s4_ovf", {31'd0, ovf}, 32'd0);
    blr = 1'b0;
    tk(1);
    chk("s4_clr_1cyc", {31'd0, clr}, 32'd0);
    chk("s4_disp", {16'd0, disp}, 32'h0000);
    tk(1);
    blr = 1'b1;
    tk(1);
    chk("s4_idle_clr", {31'd0, clr}, 32'd1);
    chk("s4_idle_stay", {31'd0, running}, 32'd0);
    blr = 1'b0;
    tk(1);
    chk("s4_idle_clr_end", {31'd0, clr}, 32'd0);

    // overflow on wrap from 9999, sticky until clear
    c = cyc;
    bss = 1'b1;
    exp_q.push_back(c + 5);
    exp_q.push_back(c + 9);
    sb_on = 1'b1;
    tk(1);
    bss = 1'b0;
    tk(4);
    load_val = 16'h9999;
    load_req = 1'b1;
    tk(1);
    load_req = 1'b0;
    tk(4);
    chk("s5_ovf", {31'd0, ovf}, 32'd1);
    chk("s5_wrap", {16'd0, disp}, 32'h0000);
    chk("s5_q", exp_q.size(), 32'd0);
    sb_on = 1'b0;
    bss = 1'b1;
    tk(1);
    chk("s5_ovf_stop", {31'd0, ovf}, 32'd1);
    bss = 1'b0;
    tk(1);
    bss = 1'b1;
    tk(1);
    chk("s5_ovf_run", {31'd0, ovf}, 32'd1);
    chk("s5_run", {31'd0, running}, 32'd1);
    bss = 1'b0;
    tk(1);
    bss = 1'b1;
    tk(1);
    bss = 1'b0;
    blr = 1'b1;
    tk(1);
    chk("s5_ovf_clr", {31'd0, ovf}, 32'd0);
    chk("s5_clr", {31'd0, clr}, 32'd1);
    blr = 1'b0;
    tk(1);

    // simultaneous buttons, then reset mid-lap
    bss = 1'b1;
    tk(1);
    bss = 1'b0;
    tk(2);
    bss = 1'b1;
    blr = 1'b1;
    tk(1);
    chk("s6_stop", {31'd0, running}, 32'd0);
    chk("s6_nolap", {31'd0, lap_act}, 32'd0);
    bss = 1'b0;
    blr = 1'b0;
    tk(1);
    chk("s6_still_stop", {31'd0, running}, 32'd0);
    bss = 1'b1;
    tk(1);
    bss = 1'b0;
    blr = 1'b1;
    tk(1);
    chk("s6_lap", {31'd0, lap_act}, 32'd1);
    blr = 1'b0;
    tk(2);
    rst = 1'b1;
    tk(1);
    chk("s6_rst_tick", {31'd0, tick}, 32'd0);
    chk("s6_rst_clr", {31'd0, clr}, 32'd0);
    chk("s6_rst_run", {31'd0, running}, 32'd0);
    chk("s6_rst_lap", {31'd0, lap_act}, 32'd0);
    chk("s6_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("s6_rst_disp", {16'd0, disp}, 32'h0000);
    bss = 1'b1;
    tk(1);
    rst = 1'b0;
    tk(1);
    chk("s6_held_btn", {31'd0, running}, 32'd1);
    bss = 1'b0;
    tk(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
